// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: block FSM states,
// default clocking constants and the clocks-per-bit helper.
package uart_pkg;

  localparam int unsigned FCLK_DEFAULT  = 100_000_000;
  localparam int unsigned FUART_DEFAULT = 115_200;

  // 1 start bit + 8 data bits + 1 stop bit.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5,
    ST_DONE  = 3'd6
  } tx_state_t;

  // Integer clocks per bit; no fractional-baud correction is applied.
  function automatic int unsigned calc_divider(input int unsigned fclk,
                                               input int unsigned fuart);
    return fclk / fuart;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer. A load pulse captures byte_in and starts a
// frame immediately with the start bit; every bit is held DIVIDER clocks.
// bit_tick marks the last clock of the current bit and bit_idx gives the
// frame position (0 = start, 1..8 = data, 9 = stop) so the block FSM can
// follow the frame without duplicating the bit timer.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned DIVIDER = 868
) (
  input  logic       clk_Tx,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       Tx_out,
  output logic       ready,
  output logic       bit_tick,
  output logic [3:0] bit_idx
);

  localparam logic [15:0] LAST_CNT = 16'(DIVIDER - 1);
  localparam logic [3:0]  STOP_IDX = 4'(FRAME_BITS - 1);
  localparam logic [3:0]  LAST_DATA_IDX = 4'(FRAME_BITS - 2);

  logic [7:0]  shift_reg;
  logic [15:0] bit_cnt;
  logic [3:0]  bit_idx_q;
  logic        active;
  logic        tx_q;

  // Frame sequencer: bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clk_Tx or posedge rst) begin
    if (rst) begin
      shift_reg <= 8'h00;
      bit_cnt   <= 16'd0;
      bit_idx_q <= 4'd0;
      active    <= 1'b0;
      tx_q      <= 1'b1;
    end else if (load) begin
      shift_reg <= byte_in;
      bit_cnt   <= 16'd0;
      bit_idx_q <= 4'd0;
      active    <= 1'b1;
      tx_q      <= 1'b0;
    end else if (active) begin
      if (bit_cnt == LAST_CNT) begin
        bit_cnt <= 16'd0;
        if (bit_idx_q == STOP_IDX) begin
          // Stop bit finished: line stays high, serializer goes idle.
          active    <= 1'b0;
          bit_idx_q <= 4'd0;
          tx_q      <= 1'b1;
        end else begin
          bit_idx_q <= bit_idx_q + 4'd1;
          if (bit_idx_q == LAST_DATA_IDX) begin
            tx_q <= 1'b1;
          end else begin
            tx_q      <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
          end
        end
      end else begin
        bit_cnt <= bit_cnt + 16'd1;
      end
    end
  end

  assign Tx_out   = tx_q;
  assign ready    = ~active;
  assign bit_tick = active && (bit_cnt == LAST_CNT);
  assign bit_idx  = bit_idx_q;

endmodule

// File: rtl/uart_tx_block.sv
// Block transmitter: on a start pulse, reads N_BYTES bytes from a
// synchronous-read memory (addresses 0..N_BYTES-1) and sends each as an
// 8N1 frame, then pulses done for one clock.
//
// Handshake: start is a request sampled only in IDLE; once accepted, busy
// stays high until the last stop bit ends, and further start requests are
// dropped (no queueing). rd_data must be valid exactly one clock after
// rd_addr changes; it is captured only in LOAD.
module uart_tx_block
  import uart_pkg::*;
#(
  parameter int unsigned Fclk    = FCLK_DEFAULT,
  parameter int unsigned Fuart   = FUART_DEFAULT,
  parameter int unsigned DIVIDER = calc_divider(Fclk, Fuart),
  parameter int unsigned N_BYTES = 113,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              clk_Tx,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              Tx_out,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] LAST_BYTE     = 8'(N_BYTES - 1);
  localparam logic [3:0] LAST_DATA_IDX = 4'(FRAME_BITS - 2);

  tx_state_t         state_q;
  tx_state_t         state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [7:0]        byte_cnt_q;
  logic              ser_load;
  logic              ser_ready;
  logic              ser_tick;
  logic [3:0]        ser_idx;

  uart_tx_byte #(
    .DIVIDER (DIVIDER)
  ) u_ser (
    .clk_Tx   (clk_Tx),
    .rst      (rst),
    .load     (ser_load),
    .byte_in  (rd_data),
    .Tx_out   (Tx_out),
    .ready    (ser_ready),
    .bit_tick (ser_tick),
    .bit_idx  (ser_idx)
  );

  // State register.
  always_ff @(posedge clk_Tx or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; START/DATA/STOP follow the serializer's bit ticks.
  always_comb begin
    state_d  = state_q;
    ser_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Memory latency clock; never reload a serializer mid-frame.
        if (ser_ready) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ser_load = 1'b1;
        state_d  = ST_START;
      end
      ST_START: begin
        if (ser_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (ser_tick && (ser_idx == LAST_DATA_IDX)) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (ser_tick) begin
          if (byte_cnt_q == LAST_BYTE) state_d = ST_DONE;
          else                         state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Address and byte counters: cleared on acceptance, stepped after each
  // stop bit except the last, so rd_addr holds N_BYTES-1 after the block.
  always_ff @(posedge clk_Tx or posedge rst) begin
    if (rst) begin
      rd_addr_q  <= '0;
      byte_cnt_q <= 8'd0;
    end else if ((state_q == ST_IDLE) && start) begin
      rd_addr_q  <= '0;
      byte_cnt_q <= 8'd0;
    end else if ((state_q == ST_STOP) && ser_tick && (byte_cnt_q != LAST_BYTE)) begin
      rd_addr_q  <= rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      byte_cnt_q <= byte_cnt_q + 8'd1;
    end
  end

  assign rd_addr = rd_addr_q;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done    = (state_q == ST_DONE);

endmodule

// File: doc/uart_tx_block.md
Name: uart_tx_block

Overview:
- UART 8N1 transmitter that streams a block of N_BYTES bytes out of a synchronous-read byte memory onto a serial line, LSB first.
- It is the send-side counterpart of the board's UART receive path. It reads the capture/result buffer (default 113 bytes) and sends it back to the host PC.
- A single start pulse sends the whole block. A done pulse marks the end of the block.

Parameters:
- Fclk, 100000000, input clock frequency [Hz]
- Fuart, 115200, baud rate [bit/s]
- DIVIDER, Fclk/Fuart (868), clocks per bit; legal range 2..65535
- N_BYTES, 113, bytes per block; legal range 1..255
- ADDR_W, 8, read address width

Ports:
- clk_Tx  in  1  single clock for the whole block
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to send one block; sampled only in IDLE
- rd_addr  out  ADDR_W  memory read address
- rd_data  in  8  memory data, valid exactly 1 clock after rd_addr changes
- Tx_out  out  1  serial line; idle high
- busy  out  1  high from start acceptance until block end
- done  out  1  1-clock pulse after the last stop bit

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - Reset values: Tx_out=1, busy=0, done=0, rd_addr=0, state=IDLE, bit counter=0, byte counter=0.
  - Reset asserted mid-frame forces Tx_out high immediately; the frame is abandoned and is not resumed.
- Frame format: 1 start bit (0), 8 data bits d[0]..d[7], 1 stop bit (1).
  - Every bit is held exactly DIVIDER clocks, timed by a 16-bit counter 0..DIVIDER-1.
  - No fractional-baud correction.
- State machine: IDLE -> FETCH -> LOAD -> START -> DATA -> STOP -> (FETCH | DONE) -> IDLE.
  - IDLE: Tx_out=1, busy=0. If start=1: rd_addr<=0, byte_cnt<=0, busy<=1, go to FETCH.
  - FETCH: 1 clock of memory latency. Tx_out stays 1.
  - LOAD: shift_reg<=rd_data, Tx_out<=0, go to START. The start-bit falling edge therefore appears 2 clocks after start is sampled.
  - START: hold Tx_out=0 for DIVIDER clocks, then go to DATA with Tx_out=shift_reg[0].
  - DATA: on every bit boundary, shift right and increment the bit index. After bit 7 has been held DIVIDER clocks, go to STOP with Tx_out=1.
  - STOP: hold Tx_out=1 for DIVIDER clocks.
    - If byte_cnt==N_BYTES-1: go to DONE.
    - Else: byte_cnt+1, rd_addr+1, go to FETCH. This adds a 2-clock idle-high gap between bytes, so the stop bit is effectively DIVIDER+2 clocks.
  - DONE: done=1 and busy=0 for 1 clock, then IDLE.
- Block timing:
  - Block duration from start sample to done pulse = N_BYTES*(10*DIVIDER+2) + 1 clocks.
  - rd_addr runs ascending 0..N_BYTES-1 and never wraps. It holds its last value until the next accepted start.
- Boundary conditions:
  - start while busy is ignored entirely (no queueing).
  - start held high continuously: a new block is accepted in the IDLE clock that follows DONE.
  - rd_data is sampled only in LOAD; changes at any other time have no effect.
  - N_BYTES=1 is legal and sends one frame, then done.

Decomposition:
- Shared package uart_pkg:
  - state encoding for the FSM
  - default Fclk/Fuart constants
  - a constant function computing DIVIDER from Fclk/Fuart
  - FRAME_BITS=10
- Sub-module uart_tx_byte: single-byte serializer.
  - Ports: clk_Tx, rst, load, byte_in[7:0], Tx_out, ready.
  - Contains the bit counter and shift register.
- uart_tx_block keeps the block FSM, address/byte counters, busy and done.

Test Plan:
- All tests use DIVIDER=4 and N_BYTES=3 unless noted.
- Reset: assert rst mid-simulation -> Tx_out=1, busy=0, done=0, rd_addr=0 within the same clock, with no clock edge needed.
- Block send: memory {0x55,0xA3,0x00}; pulse start -> Tx_out falls 2 clocks later.
  - Bit pattern per byte, each bit 4 clocks: 0,1,0,1,0,1,0,1,0,1 / 0,1,1,0,0,0,1,0,1,1 / 0,0,0,0,0,0,0,0,0,1.
  - rd_addr sequence 0,1,2.
  - done pulses once, 3*42+1=127 clocks after start sample.
- Busy rejection: second start pulse 20 clocks into byte 0 -> no change to waveform, rd_addr or done timing versus the previous test.
- Reset mid-frame: rst during the DATA state of byte 1 -> Tx_out=1 immediately. A subsequent start re-sends from rd_addr=0 with the correct byte 0 waveform.
- Continuous start held high: two full blocks back to back, with the second start bit 2 clocks after the first block's IDLE clock. Exactly 2 done pulses over 2 block durations.
- Default parameters (DIVIDER=868, N_BYTES=113, single byte checked): measured bit period = 868 clocks. rd_addr reaches 112 and done fires once.
